crc_check: RTL and testbench
============================

# crc_check

Serial CRC frame checker: the receive-side counterpart of the team's bit-serial CRC generator. It deserializes a frame of `DATA_BITS` payload bits followed by `BITS` CRC bits, both MSB first. It recomputes the CRC over the payload with the same LFSR, compares it with the received CRC, and reports pass/fail with a one-cycle done pulse. It sits behind a line decoder that supplies bit strobes and a start-of-frame marker.

## Interface
- `BITS`, 8, CRC width (2..32).
- `POLY`, 7, generator polynomial without the x^BITS term; bit i set means tap i.
- `INIT`, 0, LFSR value loaded at start of frame.
- `DATA_BITS`, 8, payload length in bits (1..64).

Ports:
- `i_clk` in 1: clock.
- `i_rst` in 1: reset, asynchronous, active-low.
- `i_stb` in 1: bit strobe; `i_bit` and `i_sof` are sampled only when high.
- `i_bit` in 1: serial bit.
- `i_sof` in 1: start of frame; when sampled with `i_stb`, the bit on that cycle is payload bit 0.
- `o_busy` out 1: high while in DATA or CRC state.
- `o_done` out 1: one-cycle pulse when a frame completes.
- `o_ok` out 1: received CRC equals computed CRC; valid from the `o_done` cycle, held until the next `o_done`.
- `o_data` out DATA_BITS: payload, first bit at MSB; held like `o_ok`.
- `o_crc_rx` out BITS: received CRC; held like `o_ok`.
- `o_crc_calc` out BITS: computed CRC; held like `o_ok`.
- `o_err_cnt` out 16: failed-frame counter (see Configuration).

## Operation
- **LFSR update** per accepted payload bit:
  - sel = lfsr[BITS-1] ^ bit
  - next[0] = POLY[0] ? sel : 0
  - next[i] = POLY[i] ? lfsr[i-1] ^ sel : lfsr[i-1]
  - No reflection, no final XOR.
- **States:** IDLE, DATA, CRC.
  - **IDLE:** `i_stb` without `i_sof` is ignored. `i_stb`&`i_sof` moves to DATA; in the same edge the LFSR takes the update of INIT with `i_bit`, the payload shift takes `i_bit`, and bitcnt = 1. If DATA_BITS = 1, go straight to CRC.
  - **DATA:** each `i_stb` updates the LFSR and shifts `i_bit` into the payload, bitcnt+1. On the edge that accepts payload bit DATA_BITS-1, go to CRC with bitcnt = 0; the LFSR is then frozen.
  - **CRC:** each `i_stb` shifts `i_bit` into the rx CRC register, bitcnt+1. On the edge that accepts CRC bit BITS-1:
    - latch `o_data`, `o_crc_rx` (including this bit) and `o_crc_calc`;
    - set `o_ok` = (rx == calc) and `o_done` = 1;
    - return to IDLE.
- **Abort/restart:** `i_stb`&`i_sof` in DATA or CRC abandons the current frame with no `o_done` and no output change. It restarts exactly as from IDLE using the current bit.
- **Back-to-back:** `i_stb`&`i_sof` on the cycle `o_done` is high starts the next frame normally; the held outputs stay until that frame's own `o_done`.
- `bitcnt` width is clog2(max(DATA_BITS, BITS)+1). There is no wrap inside a frame.

## Timing
- **Reset values:** state IDLE; `o_busy` 0, `o_done` 0, `o_ok` 0, `o_data` 0, `o_crc_rx` 0, `o_crc_calc` 0, `o_err_cnt` 0; LFSR = INIT.
- **Mid-frame reset:** reset during a frame discards it immediately.
- **Registered outputs:** all outputs are registered. `o_done` is high in the cycle after the edge that samples the last CRC bit, for exactly one cycle.
- **Latency:** minimum frame is DATA_BITS+BITS strobes; the strobe may be high every cycle.
- **`o_busy`:** rises the cycle after the sof edge and falls in the same cycle `o_done` rises.

## Configuration
- **`CRC_CHECK_ERRCNT_EN` defined:** `o_err_cnt` increments on each `o_done` with `o_ok` = 0, saturating at 0xFFFF. It is cleared only by reset.
- **Not defined:** the counter logic is absent and `o_err_cnt` is constant 0.

## Test plan
- **Good frame, 0x01:** BITS=8, POLY=7, INIT=0, DATA_BITS=8. Send payload 0x01 then CRC 0x07, strobe every cycle -> one `o_done`, `o_ok`=1, `o_data`=0x01, `o_crc_calc`=0x07.
- **Good frame, 0xFF, gapped strobes:** payload 0xFF then CRC 0xF3, with random gaps in `i_stb` -> `o_ok`=1, `o_crc_calc`=0xF3, `o_busy` high throughout.
- **Corrupted CRC:** payload 0xFF then CRC 0xF2 -> `o_ok`=0, `o_crc_rx`=0xF2, `o_crc_calc`=0xF3. With the macro defined, `o_err_cnt` goes 0 -> 1.
- **Abort/restart:** `i_sof` re-asserted at payload bit 5, then a full 0x01/0x07 frame -> exactly one `o_done`, `o_ok`=1. Stray strobes in IDLE without `i_sof` -> no state change.
- **Back-to-back:** second frame's `i_sof` coincides with the first frame's `o_done` cycle -> two `o_done` pulses DATA_BITS+BITS strobes apart, both `o_ok`=1.
- **Mid-frame reset:** `i_rst` low mid-frame -> all outputs 0 immediately; a following good frame passes.

Source files
------------

// File: rtl/crc_check_if.sv
// Bit-stream and result bundle between a line decoder (master) and the CRC
// frame checker (slave). Widths follow the checker's BITS / DATA_BITS.
interface crc_check_if #(
  parameter int BITS      = 8,
  parameter int DATA_BITS = 8
);
  logic                 i_stb;
  logic                 i_bit;
  logic                 i_sof;
  logic                 o_busy;
  logic                 o_done;
  logic                 o_ok;
  logic [DATA_BITS-1:0] o_data;
  logic [BITS-1:0]      o_crc_rx;
  logic [BITS-1:0]      o_crc_calc;
  logic [15:0]          o_err_cnt;

  modport master (
    output i_stb, i_bit, i_sof,
    input  o_busy, o_done, o_ok, o_data, o_crc_rx, o_crc_calc, o_err_cnt
  );

  modport slave (
    input  i_stb, i_bit, i_sof,
    output o_busy, o_done, o_ok, o_data, o_crc_rx, o_crc_calc, o_err_cnt
  );
endinterface

// File: rtl/crc_check.sv
// Serial CRC frame checker: deserializes payload + CRC (MSB first), recomputes the CRC
// and flags pass/fail. Define CRC_CHECK_ERRCNT_EN to build the failed-frame counter.
module crc_check #(
  parameter int          BITS      = 8,
  parameter logic [31:0] POLY      = 32'h0000_0007,
  parameter logic [31:0] INIT      = 32'h0000_0000,
  parameter int          DATA_BITS = 8
) (
  input  logic          i_clk,
  input  logic          i_rst,
  crc_check_if.slave    bus
);
  localparam int MAX_BITS = (DATA_BITS > BITS) ? DATA_BITS : BITS;
  localparam int CNT_W    = $clog2(MAX_BITS + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_CRC
  } state_t;

  state_t               state_reg, state_next;
  logic [BITS-1:0]      lfsr_reg, lfsr_next;
  logic [DATA_BITS-1:0] data_sh_reg, data_sh_next;
  logic [BITS-1:0]      rx_sh_reg, rx_sh_next;
  logic [CNT_W-1:0]     bitcnt_reg, bitcnt_next;

  logic                 busy_reg, busy_next;
  logic                 done_reg, done_next;
  logic                 ok_reg, ok_next;
  logic [DATA_BITS-1:0] data_reg, data_next;
  logic [BITS-1:0]      crc_rx_reg, crc_rx_next;
  logic [BITS-1:0]      crc_calc_reg, crc_calc_next;
  logic                 frame_fail;

  logic                 start;
  logic [BITS-1:0]      lfsr_src;
  logic [BITS-1:0]      lfsr_step;
  logic                 sel;
  logic [DATA_BITS-1:0] data_shift;
  logic [BITS-1:0]      rx_shift;

  // A start-of-frame always seeds the LFSR from INIT, even when aborting a frame.
  assign start    = bus.i_stb & bus.i_sof;
  assign lfsr_src = start ? INIT[BITS-1:0] : lfsr_reg;
  assign sel      = lfsr_src[BITS-1] ^ bus.i_bit;

  generate
    for (genvar gi = 0; gi < BITS; gi++) begin : g_lfsr
      if (gi == 0) begin : g_tap0
        assign lfsr_step[gi] = POLY[gi] ? sel : 1'b0;
      end else begin : g_tapn
        assign lfsr_step[gi] = POLY[gi] ? (lfsr_src[gi-1] ^ sel) : lfsr_src[gi-1];
      end
    end
  endgenerate

  generate
    if (DATA_BITS == 1) begin : g_data1
      assign data_shift = bus.i_bit;
    end else begin : g_datan
      assign data_shift = {data_sh_reg[DATA_BITS-2:0], bus.i_bit};
    end
  endgenerate

  assign rx_shift = {rx_sh_reg[BITS-2:0], bus.i_bit};

  always_comb begin
    state_next    = state_reg;
    lfsr_next     = lfsr_reg;
    data_sh_next  = data_sh_reg;
    rx_sh_next    = rx_sh_reg;
    bitcnt_next   = bitcnt_reg;
    done_next     = 1'b0;
    ok_next       = ok_reg;
    data_next     = data_reg;
    crc_rx_next   = crc_rx_reg;
    crc_calc_next = crc_calc_reg;
    frame_fail    = 1'b0;

    if (start) begin
      lfsr_next    = lfsr_step;
      data_sh_next = data_shift;
      if (DATA_BITS == 1) begin
        state_next  = ST_CRC;
        bitcnt_next = '0;
      end else begin
        state_next  = ST_DATA;
        bitcnt_next = CNT_W'(1);
      end
    end else if (bus.i_stb) begin
      case (state_reg)
        ST_DATA: begin
          lfsr_next    = lfsr_step;
          data_sh_next = data_shift;
          if (bitcnt_reg == CNT_W'(DATA_BITS - 1)) begin
            state_next  = ST_CRC;
            bitcnt_next = '0;
          end else begin
            bitcnt_next = bitcnt_reg + CNT_W'(1);
          end
        end
        ST_CRC: begin
          rx_sh_next = rx_shift;
          if (bitcnt_reg == CNT_W'(BITS - 1)) begin
            state_next    = ST_IDLE;
            bitcnt_next   = '0;
            done_next     = 1'b1;
            ok_next       = (rx_shift == lfsr_reg);
            frame_fail    = (rx_shift != lfsr_reg);
            data_next     = data_sh_reg;
            crc_rx_next   = rx_shift;
            crc_calc_next = lfsr_reg;
          end else begin
            bitcnt_next = bitcnt_reg + CNT_W'(1);
          end
        end
        default: begin
          // Strobes in IDLE without a start marker are line noise.
          state_next = ST_IDLE;
        end
      endcase
    end

    busy_next = (state_next != ST_IDLE);
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_reg    <= ST_IDLE;
      lfsr_reg     <= INIT[BITS-1:0];
      data_sh_reg  <= '0;
      rx_sh_reg    <= '0;
      bitcnt_reg   <= '0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      ok_reg       <= 1'b0;
      data_reg     <= '0;
      crc_rx_reg   <= '0;
      crc_calc_reg <= '0;
    end else begin
      state_reg    <= state_next;
      lfsr_reg     <= lfsr_next;
      data_sh_reg  <= data_sh_next;
      rx_sh_reg    <= rx_sh_next;
      bitcnt_reg   <= bitcnt_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
      ok_reg       <= ok_next;
      data_reg     <= data_next;
      crc_rx_reg   <= crc_rx_next;
      crc_calc_reg <= crc_calc_next;
    end
  end

`ifdef CRC_CHECK_ERRCNT_EN
  logic [15:0] err_cnt_reg;

  // Counts in step with o_done, so the count already includes the frame being reported.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      err_cnt_reg <= '0;
    end else if (frame_fail && (err_cnt_reg != 16'hFFFF)) begin
      err_cnt_reg <= err_cnt_reg + 16'd1;
    end
  end

  assign bus.o_err_cnt = err_cnt_reg;
`else
  logic unused_fail;
  assign unused_fail   = frame_fail;
  assign bus.o_err_cnt = 16'd0;
`endif

  assign bus.o_busy     = busy_reg;
  assign bus.o_done     = done_reg;
  assign bus.o_ok       = ok_reg;
  assign bus.o_data     = data_reg;
  assign bus.o_crc_rx   = crc_rx_reg;
  assign bus.o_crc_calc = crc_calc_reg;
endmodule

// File: tb/tb_crc_check.sv
// Scoreboard bench for crc_check (BITS=8, POLY=0x07, INIT=0, DATA_BITS=8):
// stimulus pushes expected frame results, a monitor pops them on each o_done.
module tb_crc_check;
  logic i_clk = 1'b0;
  logic i_rst = 1'b0;

  crc_check_if #(.BITS(8), .DATA_BITS(8)) bus ();

  crc_check #(
    .BITS(8), .POLY(32'h07), .INIT(32'h00), .DATA_BITS(8)
  ) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic       ok;
    logic [7:0] data;
    logic [7:0] rx;
    logic [7:0] calc;
  } exp_t;

  exp_t        sb[$];
  time         done_t[$];
  int          n_pass  = 0;
  int          n_total = 0;
  int          n_push  = 0;
  int          n_done  = 0;
  int          err_model = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge i_clk) begin
    if (i_rst && bus.o_done) begin
      exp_t e;
      n_done++;
      done_t.push_back($time);
      if (sb.size() == 0) begin
        check("unexpected_done", 1'b1, 1'b0);
      end else begin
        e = sb.pop_front();
        if (!e.ok) err_model++;
        check("ok",       bus.o_ok,       e.ok);
        check("data",     bus.o_data,     e.data);
        check("crc_rx",   bus.o_crc_rx,   e.rx);
        check("crc_calc", bus.o_crc_calc, e.calc);
        check("busy_at_done", bus.o_busy, 1'b0);
`ifdef CRC_CHECK_ERRCNT_EN
        check("err_cnt",  bus.o_err_cnt,  err_model);
`else
        check("err_cnt",  bus.o_err_cnt,  16'd0);
`endif
        $display("frame %0d: data=%02h rx=%02h calc=%02h ok=%0b", n_done,
                 bus.o_data, bus.o_crc_rx, bus.o_crc_calc, bus.o_ok);
      end
    end
  end

  task automatic strobe(input logic b, input logic sof);
    bus.i_stb = 1'b1;
    bus.i_bit = b;
    bus.i_sof = sof;
    @(posedge i_clk);
    #1;
    bus.i_stb = 1'b0;
    bus.i_sof = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic expect_frame(input logic [7:0] d, input logic [7:0] rx, input logic [7:0] calc);
    exp_t e;
    e.ok = (rx == calc);
    e.data = d;
    e.rx = rx;
    e.calc = calc;
    sb.push_back(e);
    n_push++;
  endtask

  // Sends payload then CRC; with gaps, idle cycles are inserted and busy is checked there.
  task automatic send_frame(input logic [7:0] d, input logic [7:0] crc, input bit gaps);
    for (int i = 15; i >= 0; i--) begin
      strobe((i >= 8) ? d[i-8] : crc[i], i == 15);
      if (gaps && i > 0) begin
        int g = $urandom_range(0, 2);
        for (int k = 0; k < g; k++) begin
          check("busy_gap", bus.o_busy, 1'b1);
          idle(1);
        end
      end
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"},  bus.o_busy,     1'b0);
    check({tag, "_done"},  bus.o_done,     1'b0);
    check({tag, "_ok"},    bus.o_ok,       1'b0);
    check({tag, "_data"},  bus.o_data,     8'h00);
    check({tag, "_rx"},    bus.o_crc_rx,   8'h00);
    check({tag, "_calc"},  bus.o_crc_calc, 8'h00);
    check({tag, "_err"},   bus.o_err_cnt,  16'h0000);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_stb = 1'b0;
    bus.i_bit = 1'b0;
    bus.i_sof = 1'b0;
    #3;
    check_outputs_zero("reset");
    @(negedge i_clk);
    i_rst = 1'b1;
    idle(2);

    // Good frame, strobe every cycle.
    expect_frame(8'h01, 8'h07, 8'h07);
    send_frame(8'h01, 8'h07, 1'b0);
    idle(3);

    // Good frame with random strobe gaps.
    expect_frame(8'hFF, 8'hF3, 8'hF3);
    send_frame(8'hFF, 8'hF3, 1'b1);
    idle(3);

    // Corrupted CRC.
    expect_frame(8'hFF, 8'hF2, 8'hF3);
    send_frame(8'hFF, 8'hF2, 1'b0);
    idle(3);

    // Stray strobes in IDLE must not start a frame.
    for (int i = 0; i < 4; i++) begin
      strobe(i[0], 1'b0);
      check("stray_busy", bus.o_busy, 1'b0);
    end
    idle(2);
    check("stray_done_cnt", n_done, 3);

    // Abort after 5 payload bits, restart with a full good frame.
    for (int i = 0; i < 5; i++) strobe(1'b1, i == 0);
    check("abort_busy", bus.o_busy, 1'b1);
    expect_frame(8'h01, 8'h07, 8'h07);
    send_frame(8'h01, 8'h07, 1'b0);
    idle(3);
    check("abort_done_cnt", n_done, 4);
    check("held_after_abort_data", bus.o_data, 8'h01);

    // Back-to-back: second sof lands in the first frame's done cycle.
    expect_frame(8'h01, 8'h07, 8'h07);
    expect_frame(8'hFF, 8'hF3, 8'hF3);
    send_frame(8'h01, 8'h07, 1'b0);
    check("b2b_done_at_sof", bus.o_done, 1'b1);
    send_frame(8'hFF, 8'hF3, 1'b0);
    idle(3);
    check("b2b_done_cnt", n_done, 6);
    if (done_t.size() >= 2)
      check("b2b_spacing", done_t[done_t.size()-1] - done_t[done_t.size()-2], 64'd160);
    else
      check("b2b_spacing_missing", done_t.size(), 2);

    // Mid-frame asynchronous reset.
    for (int i = 0; i < 6; i++) strobe(1'b0, i == 0);
    i_rst = 1'b0;
    err_model = 0;
    #1;
    check_outputs_zero("midrst");
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b1;
    idle(1);
    expect_frame(8'h01, 8'h07, 8'h07);
    send_frame(8'h01, 8'h07, 1'b0);
    idle(3);

    check("total_done_cnt", n_done, n_push);
    check("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
